// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state, index wrap
// and one-hot to binary conversion.
package rr_arb_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Explicit wrap keeps non-power-of-two widths correct without a modulo.
  function automatic int next_idx(input int i, input int width);
    return (i == width - 1) ? 0 : i + 1;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_WIDTH-1:0] oh);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if (oh[k[4:0]]) idx = idx | k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr_i,
// wrapping past WIDTH-1 back to 0.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] eligible_i,
  input  logic [SELW-1:0]  ptr_i,
  output logic [SELW-1:0]  pick_o,
  output logic             any_o
);

  localparam int CW = SELW + 1;

  // chain[k] holds the winner among offsets k..WIDTH-1; lower offsets override.
  logic [SELW-1:0] chain [WIDTH+1];

  assign chain[WIDTH] = '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_off
    logic [CW-1:0]   sum;
    logic [SELW-1:0] cand;
    assign sum  = {1'b0, ptr_i} + CW'(gi);
    assign cand = (sum >= CW'(WIDTH)) ? SELW'(sum - CW'(WIDTH)) : SELW'(sum);
    assign chain[gi] = eligible_i[cand] ? cand : chain[gi+1];
  end

  assign pick_o = chain[0];
  assign any_o  = |eligible_i;

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter that locks a grant for a whole multi-beat transaction and
// force-releases it after MAX_HOLD cycles without a last beat.
module rr_arbiter_ctrl
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SELW     = $clog2(WIDTH),
  parameter int MAX_HOLD = 64,
  parameter int HOLDW    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] req_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gnt,
  output logic [SELW-1:0]  gnt_idx,
  output logic             out_valid,
  output logic             busy,
  output logic             timeout
);

  state_t           state_q;
  logic [SELW-1:0]  ptr_q;
  logic [WIDTH-1:0] gnt_q;
  logic [HOLDW-1:0] hold_q;
  logic             timeout_q;

  logic [WIDTH-1:0] eligible;
  logic [SELW-1:0]  pick;
  logic             any_elig;
  logic             last_fire;
  logic             hold_expire;
  logic [SELW-1:0]  ptr_d;
  logic [WIDTH-1:0] gnt_d;
  logic [HOLDW-1:0] hold_d;

  assign eligible = req & mask;

  rr_pick #(
    .WIDTH(WIDTH),
    .SELW (SELW)
  ) u_pick (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .any_o     (any_elig)
  );

  assign gnt_idx     = SELW'(onehot_to_idx(MAX_WIDTH'(gnt_q)));
  assign out_valid   = |(gnt_q & req);
  assign last_fire   = out_ready & |(gnt_q & req & req_last);
  assign hold_expire = (hold_q == HOLDW'(MAX_HOLD - 1));
  assign ptr_d       = SELW'(next_idx(int'(gnt_idx), WIDTH));
  assign gnt_d       = WIDTH'(1) << pick;
  assign hold_d      = (hold_q == HOLDW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && any_elig) begin
            state_q <= LOCKED;
            gnt_q   <= gnt_d;
            hold_q  <= '0;
          end
        end
        LOCKED: begin
          // A last beat landing on the expiry cycle wins: normal release, no pulse.
          if (last_fire) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
          end else if (hold_expire) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= ptr_d;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_d;
          end
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q == LOCKED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl: a 4-way instance (MAX_HOLD=8) and a
// 3-way instance exercise rotation, multi-beat holds, masking, en and timeout.
module tb_rr_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       en4, rdy4;
  logic [3:0] mask4, req4, last4, gnt4;
  logic [1:0] idx4;
  logic       ov4, busy4, to4;

  logic       en3, rdy3;
  logic [2:0] mask3, req3, last3, gnt3;
  logic [1:0] idx3;
  logic       ov3, busy3, to3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_ctrl #(.WIDTH(4), .MAX_HOLD(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mask(mask4), .req(req4),
    .req_last(last4), .out_ready(rdy4), .gnt(gnt4), .gnt_idx(idx4),
    .out_valid(ov4), .busy(busy4), .timeout(to4)
  );

  rr_arbiter_ctrl #(.WIDTH(3), .MAX_HOLD(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mask(mask3), .req(req3),
    .req_last(last3), .out_ready(rdy3), .gnt(gnt3), .gnt_idx(idx3),
    .out_valid(ov3), .busy(busy3), .timeout(to3)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    en4 = 0; rdy4 = 0; mask4 = '0; req4 = '0; last4 = '0;
    en3 = 0; rdy3 = 0; mask3 = '0; req3 = '0; last3 = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    en4 = 1; mask4 = 4'hF; req4 = 4'hF; last4 = 4'hF; rdy4 = 1;
    step();
    step();
    checks++;
    if (gnt4 !== 4'b0000 || idx4 !== 2'd0 || busy4 !== 1'b0 || to4 !== 1'b0 || ov4 !== 1'b0) begin
      failures++;
      $display("FAIL reset4 got gnt=%b idx=%0d busy=%b to=%b ov=%b exp 0000/0/0/0/0",
               gnt4, idx4, busy4, to4, ov4);
    end
    checks++;
    if (gnt3 !== 3'b000 || busy3 !== 1'b0 || to3 !== 1'b0) begin
      failures++;
      $display("FAIL reset3 got gnt=%b busy=%b to=%b exp 000/0/0", gnt3, busy3, to3);
    end
    rst_n = 1;
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [9];
    logic [1:0] exp_i [9];
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_i = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    do_reset();
    en4 = 1; mask4 = 4'hF; req4 = 4'hF; last4 = 4'hF; rdy4 = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (gnt4 !== exp_g[i] || idx4 !== exp_i[i]) begin
        failures++;
        $display("FAIL rr_seq cyc=%0d got gnt=%b idx=%0d exp gnt=%b idx=%0d",
                 i, gnt4, idx4, exp_g[i], exp_i[i]);
      end
      $display("rr cyc=%0d gnt=%b idx=%0d", i, gnt4, idx4);
    end
  endtask

  task automatic test_multibeat;
    logic [1:0] exp_e [4];
    logic [2:0] oh;
    exp_e = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    en3 = 1; mask3 = 3'b111; req3 = 3'b111; last3 = 3'b000; rdy3 = 1;
    for (int t = 0; t < 4; t++) begin
      step();
      oh = 3'b001 << exp_e[t];
      for (int b = 0; b < 3; b++) begin
        last3 = (b == 2) ? 3'b111 : 3'b000;
        checks++;
        if (gnt3 !== oh || idx3 !== exp_e[t] || ov3 !== 1'b1 || busy3 !== 1'b1) begin
          failures++;
          $display("FAIL mb_hold txn=%0d beat=%0d got gnt=%b idx=%0d ov=%b busy=%b exp gnt=%b idx=%0d ov=1 busy=1",
                   t, b, gnt3, idx3, ov3, busy3, oh, exp_e[t]);
        end
        step();
      end
      checks++;
      if (gnt3 !== 3'b000 || busy3 !== 1'b0) begin
        failures++;
        $display("FAIL mb_dead txn=%0d got gnt=%b busy=%b exp 000/0", t, gnt3, busy3);
      end
      last3 = 3'b000;
      $display("mb txn=%0d idx=%0d", t, exp_e[t]);
    end
  endtask

  task automatic test_mask_change;
    do_reset();
    en4 = 1; mask4 = 4'hF; req4 = 4'b0010; last4 = 4'b0000; rdy4 = 1;
    step();
    checks++;
    if (gnt4 !== 4'b0010) begin
      failures++;
      $display("FAIL mask_grant got=%b exp=0010", gnt4);
    end
    req4 = 4'b0110; mask4 = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (gnt4 !== 4'b0010 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL mask_hold cyc=%0d got gnt=%b busy=%b exp 0010/1", i, gnt4, busy4);
      end
    end
    last4 = 4'b0010;
    step();
    checks++;
    if (gnt4 !== 4'b0000) begin
      failures++;
      $display("FAIL mask_release got=%b exp=0000", gnt4);
    end
    last4 = 4'b0000;
    step();
    checks++;
    if (gnt4 !== 4'b0100) begin
      failures++;
      $display("FAIL mask_next got=%b exp=0100", gnt4);
    end
    last4 = 4'b0100;
    step();
    last4 = 4'b0000;
    step();
    checks++;
    if (gnt4 !== 4'b0100 || idx4 !== 2'd2) begin
      failures++;
      $display("FAIL mask_skip got gnt=%b idx=%0d exp 0100/2", gnt4, idx4);
    end
    $display("test_mask_change done");
  endtask

  task automatic test_timeout;
    do_reset();
    en4 = 1; mask4 = 4'hF; req4 = 4'b0001; last4 = 4'b0000; rdy4 = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gnt4 !== 4'b0001 || to4 !== 1'b0 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL to_hold cyc=%0d got gnt=%b to=%b busy=%b exp 0001/0/1", i, gnt4, to4, busy4);
      end
      if (i < 7) step();
    end
    req4 = 4'hF;
    step();
    checks++;
    if (gnt4 !== 4'b0000 || to4 !== 1'b1 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL to_release got gnt=%b to=%b busy=%b exp 0000/1/0", gnt4, to4, busy4);
    end
    step();
    checks++;
    if (gnt4 !== 4'b0010 || to4 !== 1'b0) begin
      failures++;
      $display("FAIL to_next got gnt=%b to=%b exp 0010/0", gnt4, to4);
    end
    $display("test_timeout done");
  endtask

  task automatic test_en;
    do_reset();
    en4 = 0; mask4 = 4'hF; req4 = 4'hF; last4 = 4'hF; rdy4 = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
        failures++;
        $display("FAIL en_off cyc=%0d got gnt=%b busy=%b exp 0000/0", i, gnt4, busy4);
      end
    end
    en4 = 1;
    step();
    checks++;
    if (gnt4 !== 4'b0001) begin
      failures++;
      $display("FAIL en_on got=%b exp=0001", gnt4);
    end
    en4 = 0; last4 = 4'b0000;
    step();
    checks++;
    if (gnt4 !== 4'b0001 || busy4 !== 1'b1) begin
      failures++;
      $display("FAIL en_drop_hold got gnt=%b busy=%b exp 0001/1", gnt4, busy4);
    end
    last4 = 4'hF;
    step();
    checks++;
    if (gnt4 !== 4'b0000) begin
      failures++;
      $display("FAIL en_complete got=%b exp=0000", gnt4);
    end
    step();
    checks++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL en_no_regrant got gnt=%b busy=%b exp 0000/0", gnt4, busy4);
    end
    $display("test_en done");
  endtask

  task automatic test_reset_mid;
    do_reset();
    en4 = 1; mask4 = 4'hF; req4 = 4'b0001; last4 = 4'b0001; rdy4 = 1;
    step();
    step();
    req4 = 4'b0100; last4 = 4'b0000;
    step();
    checks++;
    if (gnt4 !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_grant got=%b exp=0100", gnt4);
    end
    rst_n = 0;
    step();
    checks++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || to4 !== 1'b0 || idx4 !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_clear got gnt=%b busy=%b to=%b idx=%0d exp 0000/0/0/0",
               gnt4, busy4, to4, idx4);
    end
    rst_n = 1; req4 = 4'hF;
    step();
    checks++;
    if (gnt4 !== 4'b0001 || to4 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ptr got gnt=%b to=%b exp 0001/0", gnt4, to4);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_round_robin();
    test_multibeat();
    test_mask_change();
    test_timeout();
    test_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
